if_id_queue: RTL and testbench
==============================

IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 Parameter InstrWidth, default 16, SHALL set the instruction field width.
REQ-002 Parameter PCWidth, default 16, SHALL set the PC field width.
REQ-003 Parameter Depth, default 4, SHALL set the entry count; legal values are powers of two, 2 to 16.
REQ-004 CLK  in  1  SHALL be the single clock; all state updates on rising edge.
REQ-005 RST  in  1  SHALL be a synchronous, active-low reset sampled on rising CLK.
REQ-006 In_Valid  in  1  SHALL mean fetch presents an entry this cycle.
REQ-007 In_Ready  out  1  SHALL mean the queue accepts an entry this cycle.
REQ-008 Instruction_In  in  InstrWidth, PC_In  in  PCWidth, Branch_Taken_In  in  1  SHALL carry the fetched entry.
REQ-009 Stall  in  1  SHALL mean decode refuses the head entry this cycle.
REQ-010 Flush  in  1  SHALL discard all held entries.
REQ-011 Out_Valid  out  1  SHALL mean the head entry is valid.
REQ-012 Instruction_Out  out  InstrWidth, PC_Out  out  PCWidth, Branch_Taken_Out  out  1  SHALL present the head entry.
REQ-013 Count  out  clog2(Depth)+1  SHALL report the number of held entries.

Function
REQ-014 Push SHALL occur on a rising edge when In_Valid=1, In_Ready=1 and Flush=0.
REQ-015 Pop SHALL occur on a rising edge when Out_Valid=1, Stall=0 and Flush=0.
REQ-016 In_Ready SHALL equal (Count != Depth), registered-state only, with no combinational path from Stall.
REQ-017 Out_Valid SHALL equal (Count != 0).
REQ-018 Outputs SHALL drive the head entry combinationally from storage; when Count=0 they SHALL be all-zero (NOP bubble).
REQ-019 Latency SHALL be one cycle: an entry pushed at edge N appears at the outputs after edge N if the queue was empty.
REQ-020 Order SHALL be strict FIFO; the three fields of an entry SHALL always travel together.
REQ-021 Simultaneous push and pop SHALL leave Count unchanged and advance both pointers.
REQ-022 Read and write pointers SHALL wrap from Depth-1 to 0.
REQ-023 Flush=1 SHALL, at the next edge, set Count=0 and both pointers=0, and SHALL drop any same-cycle push and pop.
REQ-024 Stall=1 with Count=0 SHALL have no effect; a push in the same cycle SHALL still occur.
REQ-025 When full, In_Valid=1 SHALL be ignored and no entry overwritten, even if a pop occurs that cycle.
REQ-026 Storage contents SHALL be don't-care outside valid slots; only Count and pointers define validity.

Reset
REQ-027 RST=0 at a rising edge SHALL set Count=0, both pointers=0, Out_Valid=0, In_Ready=1 and all data outputs to 0.
REQ-028 RST SHALL take priority over Flush, push and pop; a reset mid-stream SHALL discard all entries.
REQ-029 The first push SHALL be accepted on the first edge after RST returns to 1.

Structure
REQ-030 Default widths and depth SHALL be defined in the shared pipeline definitions include file, common to all stage registers.
REQ-031 Entry storage SHALL be one sub-module, if_id_queue_mem: a Depth x (InstrWidth+PCWidth+1) array with one write and one asynchronous read port.
REQ-032 Pointer and count logic SHALL be in if_id_queue; the expected size is 120-250 lines total.

Verification
REQ-033 Reset, then push Instr=36, PC=54, BT=1 with Stall=0 -> after one edge, Out_Valid=1, outputs 36/54/1, Count=1; next edge pops it, Count=0, outputs 0.
REQ-034 Stall=1, push 4 entries (Instr 1..4) -> Count=4, In_Ready=0, a 5th push (Instr=5) ignored; release Stall -> outputs 1,2,3,4 on consecutive cycles.
REQ-035 Count=2, push and pop in the same cycle -> Count stays 2, head advances; run 10 cycles to exercise pointer wrap, with order preserved.
REQ-036 Count=3, Flush=1 with In_Valid=1 (Instr=25, PC=78) -> next edge Count=0, Out_Valid=0, outputs 0, entry 25 not stored.
REQ-037 Count=2, RST=0 together with Flush=1 and In_Valid=1 -> next edge Count=0, In_Ready=1; a push after RST=1 shows as head one edge later.

Source files
------------

// File: rtl/if_id_queue_pkg.sv
// Shared pipeline definitions for the fetch/decode stage registers.
// Default widths and depth used by every stage queue.
package if_id_queue_pkg;

    localparam int DEF_INSTR_W = 16;
    localparam int DEF_PC_W    = 16;
    localparam int DEF_DEPTH   = 4;

    // Packed entry layout is {instruction, pc, branch_taken}.
    function automatic int entry_width(input int instr_w, input int pc_w);
        return instr_w + pc_w + 1;
    endfunction

endpackage

// File: rtl/if_id_queue_mem.sv
// Entry storage for the fetch/decode queue: one synchronous write port and
// one asynchronous read port. Contents are not reset.
module if_id_queue_mem #(
    parameter int Depth = 4,
    parameter int Width = 33
) (
    input  logic                     CLK,
    input  logic                     wr_en,
    input  logic [$clog2(Depth)-1:0] wr_addr,
    input  logic [Width-1:0]         wr_data,
    input  logic [$clog2(Depth)-1:0] rd_addr,
    output logic [Width-1:0]         rd_data
);

    logic [Width-1:0] mem [Depth];

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: strict FIFO of {instruction, pc,
// branch_taken} entries with flush, decode stall and a zero bubble when empty.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int InstrWidth = DEF_INSTR_W,
    parameter int PCWidth    = DEF_PC_W,
    parameter int Depth      = DEF_DEPTH
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    In_Valid,
    output logic                    In_Ready,
    input  logic [InstrWidth-1:0]   Instruction_In,
    input  logic [PCWidth-1:0]      PC_In,
    input  logic                    Branch_Taken_In,
    input  logic                    Stall,
    input  logic                    Flush,
    output logic                    Out_Valid,
    output logic [InstrWidth-1:0]   Instruction_Out,
    output logic [PCWidth-1:0]      PC_Out,
    output logic                    Branch_Taken_Out,
    output logic [$clog2(Depth):0]  Count
);

    localparam int AW = $clog2(Depth);
    localparam int CW = AW + 1;
    localparam int EW = entry_width(InstrWidth, PCWidth);
    localparam logic [CW-1:0] FULL_CNT = CW'(Depth);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic [EW-1:0] head;

    // Ready/valid come from registered count only, so Stall never reaches In_Ready.
    assign In_Ready  = (count != FULL_CNT);
    assign Out_Valid = (count != '0);
    assign push      = In_Valid & In_Ready & ~Flush;
    assign pop       = Out_Valid & ~Stall & ~Flush;

    always_ff @(posedge CLK) begin
        if (!RST || Flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    if_id_queue_mem #(
        .Depth (Depth),
        .Width (EW)
    ) u_mem (
        .CLK     (CLK),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data ({Instruction_In, PC_In, Branch_Taken_In}),
        .rd_addr (rd_ptr),
        .rd_data (head)
    );

    // Empty queue presents an all-zero NOP bubble regardless of stale storage.
    always_comb begin
        Instruction_Out  = '0;
        PC_Out           = '0;
        Branch_Taken_Out = 1'b0;
        if (Out_Valid) begin
            {Instruction_Out, PC_Out, Branch_Taken_Out} = head;
        end
    end

    assign Count = count;

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed vector table, hand sequences for
// same-cycle push/pop wrap, then random traffic against a queue model.
module tb_if_id_queue;

    localparam int DEPTH = 4;

    logic        CLK;
    logic        RST;
    logic        In_Valid;
    logic        In_Ready;
    logic [15:0] Instruction_In;
    logic [15:0] PC_In;
    logic        Branch_Taken_In;
    logic        Stall;
    logic        Flush;
    logic        Out_Valid;
    logic [15:0] Instruction_Out;
    logic [15:0] PC_Out;
    logic        Branch_Taken_Out;
    logic [2:0]  Count;

    int n_vec = 0;
    int n_bad = 0;

    if_id_queue #(.InstrWidth(16), .PCWidth(16), .Depth(DEPTH)) dut (
        .CLK              (CLK),
        .RST              (RST),
        .In_Valid         (In_Valid),
        .In_Ready         (In_Ready),
        .Instruction_In   (Instruction_In),
        .PC_In            (PC_In),
        .Branch_Taken_In  (Branch_Taken_In),
        .Stall            (Stall),
        .Flush            (Flush),
        .Out_Valid        (Out_Valid),
        .Instruction_Out  (Instruction_Out),
        .PC_Out           (PC_Out),
        .Branch_Taken_Out (Branch_Taken_Out),
        .Count            (Count)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic        rst, iv;
        logic [15:0] ins, pc;
        logic        bt, st, fl;
        logic [2:0]  ecnt;
        logic        eov, eir;
        logic [15:0] eins, epc;
        logic        ebt;
    } vec_t;

    vec_t vt[$];

    // Reference model: queue of {instr, pc, bt}.
    logic [32:0] mq[$];

    function automatic vec_t mk(input logic rst, iv, input logic [15:0] ins, pc,
                                input logic bt, st, fl, input logic [2:0] ecnt,
                                input logic eov, eir, input logic [15:0] eins, epc,
                                input logic ebt);
        vec_t v;
        v.rst = rst; v.iv = iv; v.ins = ins; v.pc = pc; v.bt = bt; v.st = st; v.fl = fl;
        v.ecnt = ecnt; v.eov = eov; v.eir = eir; v.eins = eins; v.epc = epc; v.ebt = ebt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, iv, input logic [15:0] ins, pc, input logic bt, st, fl);
        RST = r; In_Valid = iv; Instruction_In = ins; PC_In = pc;
        Branch_Taken_In = bt; Stall = st; Flush = fl;
    endtask

    task automatic check_model(input string tag);
        logic [32:0] h;
        h = (mq.size() == 0) ? 33'd0 : mq[0];
        chk({tag, "_count"}, 32'(Count), 32'(mq.size()));
        chk({tag, "_ovalid"}, 32'(Out_Valid), 32'(mq.size() != 0));
        chk({tag, "_iready"}, 32'(In_Ready), 32'(mq.size() != DEPTH));
        chk({tag, "_instr"}, 32'(Instruction_Out), 32'(h[32:17]));
        chk({tag, "_pc"}, 32'(PC_Out), 32'(h[16:1]));
        chk({tag, "_bt"}, 32'(Branch_Taken_Out), 32'(h[0]));
    endtask

    task automatic mstep(input string tag, input logic r, iv, input logic [15:0] ins, pc,
                         input logic bt, st, fl);
        logic do_push, do_pop;
        drive(r, iv, ins, pc, bt, st, fl);
        #1;
        chk({tag, "_pre_iready"}, 32'(In_Ready), 32'(mq.size() != DEPTH));
        if (!r || fl) begin
            mq.delete();
        end else begin
            do_push = iv && (mq.size() != DEPTH);
            do_pop  = (mq.size() != 0) && !st;
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back({ins, pc, bt});
        end
        @(posedge CLK);
        #1;
        check_model(tag);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);

        vt.push_back(mk(0,0, 0,  0,0,0,0, 0,0,1,  0,  0,0));
        vt.push_back(mk(1,1,36, 54,1,0,0, 1,1,1, 36, 54,1));
        vt.push_back(mk(1,0, 0,  0,0,0,0, 0,0,1,  0,  0,0));
        vt.push_back(mk(1,1, 1,101,1,1,0, 1,1,1,  1,101,1));
        vt.push_back(mk(1,1, 2,102,0,1,0, 2,1,1,  1,101,1));
        vt.push_back(mk(1,1, 3,103,1,1,0, 3,1,1,  1,101,1));
        vt.push_back(mk(1,1, 4,104,0,1,0, 4,1,0,  1,101,1));
        vt.push_back(mk(1,1, 5,105,1,1,0, 4,1,0,  1,101,1));
        vt.push_back(mk(1,0, 0,  0,0,0,0, 3,1,1,  2,102,0));
        vt.push_back(mk(1,0, 0,  0,0,0,0, 2,1,1,  3,103,1));
        vt.push_back(mk(1,0, 0,  0,0,0,0, 1,1,1,  4,104,0));
        vt.push_back(mk(1,0, 0,  0,0,0,0, 0,0,1,  0,  0,0));
        vt.push_back(mk(1,1, 7,107,1,1,0, 1,1,1,  7,107,1));
        vt.push_back(mk(1,1, 8,108,0,1,0, 2,1,1,  7,107,1));
        vt.push_back(mk(1,1, 9,109,1,1,0, 3,1,1,  7,107,1));
        vt.push_back(mk(1,1,25, 78,1,0,1, 0,0,1,  0,  0,0));
        vt.push_back(mk(1,1,10,110,0,1,0, 1,1,1, 10,110,0));
        vt.push_back(mk(1,1,11,111,1,1,0, 2,1,1, 10,110,0));
        vt.push_back(mk(0,1,12,112,0,0,1, 0,0,1,  0,  0,0));
        vt.push_back(mk(1,1,13,113,1,1,0, 1,1,1, 13,113,1));
        vt.push_back(mk(1,0, 0,  0,0,0,0, 0,0,1,  0,  0,0));
        vt.push_back(mk(1,1,20,120,0,1,0, 1,1,1, 20,120,0));
        vt.push_back(mk(1,1,21,121,1,1,0, 2,1,1, 20,120,0));
        vt.push_back(mk(1,1,22,122,0,1,0, 3,1,1, 20,120,0));
        vt.push_back(mk(1,1,23,123,1,1,0, 4,1,0, 20,120,0));
        vt.push_back(mk(1,1,99,199,1,0,0, 3,1,1, 21,121,1));
        vt.push_back(mk(1,0, 0,  0,0,0,0, 2,1,1, 22,122,0));
        vt.push_back(mk(1,0, 0,  0,0,0,0, 1,1,1, 23,123,1));
        vt.push_back(mk(1,0, 0,  0,0,0,0, 0,0,1,  0,  0,0));

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].rst, vt[i].iv, vt[i].ins, vt[i].pc, vt[i].bt, vt[i].st, vt[i].fl);
            @(posedge CLK);
            #1;
            chk($sformatf("v%0d_count", i), 32'(Count), 32'(vt[i].ecnt));
            chk($sformatf("v%0d_ovalid", i), 32'(Out_Valid), 32'(vt[i].eov));
            chk($sformatf("v%0d_iready", i), 32'(In_Ready), 32'(vt[i].eir));
            chk($sformatf("v%0d_instr", i), 32'(Instruction_Out), 32'(vt[i].eins));
            chk($sformatf("v%0d_pc", i), 32'(PC_Out), 32'(vt[i].epc));
            chk($sformatf("v%0d_bt", i), 32'(Branch_Taken_Out), 32'(vt[i].ebt));
        end

        // Hold count at 2 while pushing and popping together; pointers wrap twice.
        mstep("wr_rst", 0, 0, 0, 0, 0, 0, 0);
        mstep("wr_a", 1, 1, 16'd200, 16'd300, 1'b0, 1, 0);
        mstep("wr_b", 1, 1, 16'd201, 16'd301, 1'b1, 1, 0);
        for (int i = 0; i < 10; i++) begin
            mstep($sformatf("wrap%0d", i), 1, 1, 16'(202 + i), 16'(302 + i), 1'(i), 0, 0);
            chk($sformatf("wrap%0d_hold2", i), 32'(Count), 32'd2);
            chk($sformatf("wrap%0d_head", i), 32'(Instruction_Out), 32'(201 + i));
        end

        // Full queue: releasing Stall must not raise In_Ready before the edge.
        mstep("fs_rst", 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            mstep($sformatf("fs_fill%0d", i), 1, 1, 16'(40 + i), 16'(140 + i), 1'b1, 1, 0);
        end
        drive(1, 1, 16'd77, 16'd177, 1'b0, 0, 0);
        #1;
        chk("nostall_path_iready", 32'(In_Ready), 32'd0);

        mstep("rnd_rst", 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            mstep($sformatf("rnd%0d", i),
                  ($urandom % 60) != 0,
                  ($urandom % 4) != 0,
                  16'($urandom), 16'($urandom), 1'($urandom),
                  ($urandom % 3) == 0,
                  ($urandom % 25) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
